// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/booth_seq_core.sv
// Radix-2 Booth sequential multiplier: one add/sub-and-shift step per cycle,
// WIDTH steps per product. o_done flags the cycle in which the last step runs.
module booth_seq_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_p
);

  localparam int CW = $clog2(WIDTH) + 1;

  // One guard bit on acc/m keeps the most negative multiplicand from overflowing.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_q0;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q0})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
  end

  assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_p    = {r_acc[WIDTH-1:0], r_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_q0  <= 1'b0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_acc <= '0;
      r_m   <= {i_a[WIDTH-1], i_a};
      r_q   <= i_b;
      r_q0  <= 1'b0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      r_q0  <= r_q[0];
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter feeding one shared sequential Booth multiplier.
// Optional per-requester completion counters: define BOOTH_ARB_PERF_EN.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*WIDTH-1:0]        rsp_p,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
`ifdef BOOTH_ARB_PERF_EN
  output logic [NREQ*16-1:0]        perf_ops,
`endif
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_gnt;
  logic             w_any;
  logic             w_xfer;
  logic             w_core_done;
  logic [2*WIDTH-1:0] w_core_p;

  // First valid requester at or after r_ptr, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = IDW'(idx);
      end
    end
  end

  assign w_xfer = (r_state == IDLE) && w_any && !rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer)      w_next = CALC;
      CALC:    if (w_core_done) w_next = DONE;
      DONE:    if (rsp_ready)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
    end else if (w_xfer) begin
      r_id  <= w_gnt;
      r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
    end
  end

  booth_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_xfer),
    .i_a     (req_a[w_gnt*WIDTH +: WIDTH]),
    .i_b     (req_b[w_gnt*WIDTH +: WIDTH]),
    .o_done  (w_core_done),
    .o_p     (w_core_p)
  );

  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_p     = w_core_p;

`ifdef BOOTH_ARB_PERF_EN
  logic [15:0] r_perf [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_perf[i] <= '0;
    end else if (rsp_valid && rsp_ready) begin
      r_perf[r_id] <= r_perf[r_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    assign perf_ops[g*16 +: 16] = r_perf[g];
  end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed self-checking bench for booth_mul_arbiter (NREQ=4, WIDTH=8).
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef BOOTH_ARB_PERF_EN
  logic [63:0] perf_ops;
`endif

  int passCount  = 0;
  int totalCount = 0;
  int cycleCount = 0;

  booth_mul_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
`ifdef BOOTH_ARB_PERF_EN
    .perf_ops  (perf_ops),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                               input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one request, check grant, latency, product and id; returns at the first DONE negedge.
  task automatic doOp(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, input int expId, input logic [15:0] expP, input string tag);
    int n;
    int lat;
    @(posedge clk);
    #1 applyStimulus(v, a, b, rr);
    @(negedge clk);
    n = 0;
    while (req_ready === 4'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << expId));
    @(posedge clk);
    #1 req_valid = 4'b0;
    lat = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd9);
    checkOutput({tag, "_p"}, 32'(rsp_p), 32'(expP));
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(expId));
  endtask

  initial begin
    int n;
    int lat;
    int prevGrant;
    int g;
    logic sawValid;
    logic [15:0] rrP [5];
    rrP = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};

    applyStimulus(4'b1111, '0, '0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_p", 32'(rsp_p), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = 4'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op and corner operands, all from requester 0
    doOp(4'b0001, {24'h0, 8'd5},    {24'h0, 8'hFE}, 1'b1, 0, 16'hFFF6, "single");
    checkOutput("single_busy_done", 32'(busy), 32'd1);
    doOp(4'b0001, {24'h0, 8'h80},   {24'h0, 8'h80}, 1'b1, 0, 16'h4000, "min_x_min");
    doOp(4'b0001, {24'h0, 8'h80},   {24'h0, 8'h7F}, 1'b1, 0, 16'hC080, "min_x_max");
    doOp(4'b0001, {24'h0, 8'h00},   {24'h0, 8'h01}, 1'b1, 0, 16'h0000, "zero_x_one");
    doOp(4'b0001, {24'h0, 8'h7F},   {24'h0, 8'h7F}, 1'b1, 0, 16'h3F01, "max_x_max");
    doOp(4'b0001, {24'h0, 8'hFF},   {24'h0, 8'hFF}, 1'b1, 0, 16'h0001, "neg1_x_neg1");
    @(negedge clk);
    checkOutput("return_idle_busy", 32'(busy), 32'd0);

    // Round robin with all four requesters held valid
    doReset();
    applyStimulus(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd3}}, 1'b1);
    prevGrant = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      @(negedge clk);
      n = 0;
      while (req_ready === 4'b0 && n < 30) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << g));
      if (k > 0) checkOutput($sformatf("rr%0d_period", k), 32'(cycleCount - prevGrant), 32'd10);
      prevGrant = cycleCount;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("rr%0d_latency", k), 32'(lat), 32'd9);
      checkOutput($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(g));
      checkOutput($sformatf("rr%0d_p", k), 32'(rsp_p), 32'(rrP[k]));
      checkOutput($sformatf("rr%0d_done_ready", k), 32'(req_ready), 32'd0);
    end
    req_valid = 4'b0;

    // Backpressure: hold DONE for 5 cycles with competing requests present
    doOp(4'b0010, {16'h0, 8'hF9, 8'h0}, {16'h0, 8'd9, 8'h0}, 1'b0, 1, 16'hFFC1, "bp");
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_p", k), 32'(rsp_p), 32'hFFC1);
      checkOutput($sformatf("bp_hold%0d_id", k), 32'(rsp_id), 32'd1);
      checkOutput($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 32'd0);
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);

    // Reset during CALC cycle 4 aborts the op and rewinds the pointer
    @(posedge clk);
    #1 applyStimulus(4'b0010, {16'h0, 8'd9, 8'h0}, {16'h0, 8'd9, 8'h0}, 1'b1);
    @(negedge clk);
    checkOutput("abort_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = 4'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("abort_no_rsp", 32'(sawValid), 32'd0);
    checkOutput("abort_busy_after", 32'(busy), 32'd0);
    doOp(4'b1010, {8'd4, 8'd0, 8'd2, 8'd0}, {8'd4, 8'd0, 8'd3, 8'd0}, 1'b1, 1, 16'd6, "post_abort");

`ifdef BOOTH_ARB_PERF_EN
    doReset();
    doOp(4'b0100, {8'd0, 8'd2, 16'h0}, {8'd0, 8'd3, 16'h0}, 1'b1, 2, 16'd6, "perf_op0");
    doOp(4'b0100, {8'd0, 8'd3, 16'h0}, {8'd0, 8'd3, 16'h0}, 1'b1, 2, 16'd9, "perf_op1");
    doOp(4'b0100, {8'd0, 8'd4, 16'h0}, {8'd0, 8'd3, 16'h0}, 1'b1, 2, 16'd12, "perf_op2");
    @(negedge clk);
    checkOutput("perf_req0", 32'(perf_ops[15:0]),  32'd0);
    checkOutput("perf_req1", 32'(perf_ops[31:16]), 32'd0);
    checkOutput("perf_req2", 32'(perf_ops[47:32]), 32'd3);
    checkOutput("perf_req3", 32'(perf_ops[63:48]), 32'd0);
    doReset();
    @(negedge clk);
    checkOutput("perf_cleared", 32'(perf_ops[47:32]), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
